// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the execute-stage multiply/divide unit:
// funct3 opcodes, FSM state encoding and operand-signedness helpers.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } mdu_state_e;

  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // MULHSU treats rs2 as unsigned, so only three opcodes sign rs2.
  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/mdu_iterative_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface mdu_iterative_if #(
  parameter int XLEN = rv32_pkg::XLEN
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic            wb_en;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, op_a, op_b, rd_in,
    input  busy, done, wb_en, result, rd_out
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in,
    output busy, done, wb_en, result, rd_out
  );
endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation; used for operand magnitudes and
// for restoring the sign of the final product/quotient/remainder.
module mdu_sign_fix #(
  parameter int W = 64
) (
  input  logic         neg,
  input  logic [W-1:0] value,
  output logic [W-1:0] fixed
);

  // Negate when requested, pass through otherwise.
  always_comb begin
    if (neg) begin
      fixed = ~value + {{(W-1){1'b0}}, 1'b1};
    end else begin
      fixed = value;
    end
  end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with divide fast paths.
module mdu_iterative #(
  parameter int XLEN  = rv32_pkg::XLEN,
  parameter int CNT_W = 6
) (
  input logic            clk,
  input logic            rst,
  mdu_iterative_if.slave bus
);
  import rv32_pkg::*;

  localparam int DW = 2 * XLEN;
  localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  mdu_state_e      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]      f3_r;
  logic            sign_r;
  logic [XLEN-1:0] mpl_r;   // multiplier, or dividend shifting out / quotient shifting in
  logic [DW-1:0]   mcd_r;   // shifted multiplicand, or divisor in the low word
  logic [DW-1:0]   acc_r;   // product accumulator, or partial remainder in the low word
  logic [4:0]      rd_r;
  logic            busy_r;
  logic            done_r;
  logic [XLEN-1:0] result_r;
  logic [4:0]      rd_out_r;

  logic            neg_a_s;
  logic            neg_b_s;
  logic [XLEN-1:0] abs_a_s;
  logic [XLEN-1:0] abs_b_s;
  logic            sign_s;
  logic            div_zero_s;
  logic            ovf_s;
  logic [XLEN-1:0] fast_res_s;
  logic [DW-1:0]   acc_nxt_s;
  logic [DW-1:0]   mcd_nxt_s;
  logic [XLEN-1:0] mpl_nxt_s;
  logic [XLEN:0]   shifted_s;
  logic [XLEN:0]   trial_s;
  logic [DW-1:0]   raw_s;
  logic [DW-1:0]   fixed_s;
  logic [XLEN-1:0] res_sel_s;

  assign neg_a_s = is_signed_a(bus.funct3) & bus.op_a[XLEN-1];
  assign neg_b_s = is_signed_b(bus.funct3) & bus.op_b[XLEN-1];

  mdu_sign_fix #(.W(XLEN)) u_abs_a (.neg(neg_a_s), .value(bus.op_a), .fixed(abs_a_s));
  mdu_sign_fix #(.W(XLEN)) u_abs_b (.neg(neg_b_s), .value(bus.op_b), .fixed(abs_b_s));

  // Request decode: result sign and the divide fast-path results.
  always_comb begin
    sign_s     = 1'b0;
    div_zero_s = bus.funct3[2] && (bus.op_b == ZERO);
    ovf_s      = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
                 (bus.op_a == MIN_NEG) && (bus.op_b == ONES);
    case (bus.funct3)
      F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU, F3_DIV: sign_s = neg_a_s ^ neg_b_s;
      F3_REM:                                       sign_s = neg_a_s;
      default:                                      sign_s = 1'b0;
    endcase
    if (div_zero_s) begin
      fast_res_s = bus.funct3[1] ? bus.op_a : ONES;
    end else if (ovf_s) begin
      fast_res_s = bus.funct3[1] ? ZERO : MIN_NEG;
    end else begin
      fast_res_s = ZERO;
    end
  end

  // One iteration step of the shift-add multiply or restoring divide.
  always_comb begin
    acc_nxt_s = acc_r;
    mcd_nxt_s = mcd_r;
    mpl_nxt_s = mpl_r;
    shifted_s = {acc_r[XLEN-1:0], mpl_r[XLEN-1]};
    trial_s   = shifted_s - {1'b0, mcd_r[XLEN-1:0]};
    if (f3_r[2]) begin
      // Remainder stays below the divisor, so a set top bit means the trial went negative.
      if (!trial_s[XLEN]) begin
        acc_nxt_s = {{(XLEN-1){1'b0}}, trial_s};
        mpl_nxt_s = {mpl_r[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt_s = {{(XLEN-1){1'b0}}, shifted_s};
        mpl_nxt_s = {mpl_r[XLEN-2:0], 1'b0};
      end
    end else begin
      if (mpl_r[0]) begin
        acc_nxt_s = acc_r + mcd_r;
      end else begin
        acc_nxt_s = acc_r;
      end
      mcd_nxt_s = {mcd_r[DW-2:0], 1'b0};
      mpl_nxt_s = {1'b0, mpl_r[XLEN-1:1]};
    end
  end

  // Final value selection from the last iteration, sign-corrected.
  always_comb begin
    case (f3_r)
      F3_DIV, F3_DIVU: raw_s = {ZERO, mpl_nxt_s};
      F3_REM, F3_REMU: raw_s = {ZERO, acc_nxt_s[XLEN-1:0]};
      default:         raw_s = acc_nxt_s;
    endcase
  end

  mdu_sign_fix #(.W(DW)) u_fix_res (.neg(sign_r), .value(raw_s), .fixed(fixed_s));

  // Word select: high half for the MULH family, low half otherwise.
  always_comb begin
    case (f3_r)
      F3_MULH, F3_MULHSU, F3_MULHU: res_sel_s = fixed_s[DW-1:XLEN];
      default:                      res_sel_s = fixed_s[XLEN-1:0];
    endcase
  end

  // Control FSM with iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= S_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      f3_r     <= 3'b000;
      sign_r   <= 1'b0;
      mpl_r    <= ZERO;
      mcd_r    <= {DW{1'b0}};
      acc_r    <= {DW{1'b0}};
      rd_r     <= 5'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= ZERO;
      rd_out_r <= 5'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          if (bus.start) begin
            f3_r   <= bus.funct3;
            rd_r   <= bus.rd_in;
            sign_r <= sign_s;
            cnt_r  <= {CNT_W{1'b0}};
            acc_r  <= {DW{1'b0}};
            if (bus.funct3[2]) begin
              mpl_r <= abs_a_s;
              mcd_r <= {ZERO, abs_b_s};
            end else begin
              mpl_r <= abs_b_s;
              mcd_r <= {ZERO, abs_a_s};
            end
            if (div_zero_s || ovf_s) begin
              state_r  <= S_DONE;
              done_r   <= 1'b1;
              result_r <= fast_res_s;
              rd_out_r <= bus.rd_in;
            end else begin
              state_r <= S_CALC;
              busy_r  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          acc_r <= acc_nxt_s;
          mcd_r <= mcd_nxt_s;
          mpl_r <= mpl_nxt_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            state_r  <= S_DONE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            result_r <= res_sel_s;
            rd_out_r <= rd_r;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.wb_en  = done_r;
  assign bus.result = result_r;
  assign bus.rd_out = rd_out_r;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed RV32M cases, fast paths,
// handshake corner cases and randomized operations against a wide-arithmetic model.
module tb_mdu_iterative;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mdu_iterative_if #(.XLEN(32)) bus ();

  mdu_iterative #(.XLEN(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Architectural result computed with 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] ua, ub, up;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f3)
      3'd0: begin up = ua * ub; r = up[31:0]; end
      3'd1: begin sp = sa * sb; r = sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub); r = sp[63:32]; end
      3'd3: begin up = ua * ub; r = up[63:32]; end
      3'd4: begin if (b == 32'h0) r = 32'hFFFF_FFFF; else begin sp = sa / sb; r = sp[31:0]; end end
      3'd5: begin if (b == 32'h0) r = 32'hFFFF_FFFF; else r = a / b; end
      3'd6: begin if (b == 32'h0) r = a; else begin sp = sa % sb; r = sp[31:0]; end end
      default: begin if (b == 32'h0) r = a; else r = a % b; end
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && ((b == 32'h0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one request and observe it until one cycle past its done pulse.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        output logic [31:0] res, output logic [4:0] rdo, output int done_cyc,
                        output int busy_cyc, output int done_cnt, output int wb_bad);
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f3; bus.op_a = a; bus.op_b = b; bus.rd_in = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.op_a = $urandom; bus.op_b = $urandom; bus.rd_in = 5'($urandom);
    res = 32'hx; rdo = 5'hx; done_cyc = 0; busy_cyc = 0; done_cnt = 0; wb_bad = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.wb_en !== bus.done) wb_bad++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) begin done_cyc = n; res = bus.result; rdo = bus.rd_out; end
      end
      if (done_cyc != 0 && n > done_cyc) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0; bus.funct3 = 3'd0; bus.op_a = 32'h0; bus.op_b = 32'h0; bus.rd_in = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en: got %b expected 0", bus.wb_en); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.result); end
    checks++; if (bus.rd_out !== 5'd0) begin errors++; $display("FAIL reset_rd_out: got %0d expected 0", bus.rd_out); end
    rst = 1'b1;
  endtask

  task automatic test_directed();
    logic [2:0]  f3s [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] as  [8] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs  [8] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ex  [8] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    logic [31:0] res; logic [4:0] rdo; int dc, bc, dn, wb;
    for (int i = 0; i < 8; i++) begin
      run_op(f3s[i], as[i], bs[i], 5'(i + 5), res, rdo, dc, bc, dn, wb);
      checks++; if (res !== ex[i]) begin errors++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, ex[i]); end
      checks++; if (rdo !== 5'(i + 5)) begin errors++; $display("FAIL directed_rd_out[%0d]: got %0d expected %0d", i, rdo, i + 5); end
      checks++; if (dc != 33) begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected 33", i, dc); end
      checks++; if (bc != 32) begin errors++; $display("FAIL directed_busy_cycles[%0d]: got %0d expected 32", i, bc); end
      checks++; if (dn != 1 || wb != 0) begin errors++; $display("FAIL directed_done_pulse[%0d]: got done=%0d wb_mismatch=%0d expected 1/0", i, dn, wb); end
    end
  endtask

  task automatic test_fast_path();
    logic [2:0]  f3s [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex  [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [31:0] res; logic [4:0] rdo; int dc, bc, dn, wb;
    for (int i = 0; i < 4; i++) begin
      run_op(f3s[i], as[i], bs[i], 5'(i + 20), res, rdo, dc, bc, dn, wb);
      checks++; if (res !== ex[i]) begin errors++; $display("FAIL fast_result[%0d]: got %h expected %h", i, res, ex[i]); end
      checks++; if (rdo !== 5'(i + 20)) begin errors++; $display("FAIL fast_rd_out[%0d]: got %0d expected %0d", i, rdo, i + 20); end
      checks++; if (dc != 1) begin errors++; $display("FAIL fast_latency[%0d]: got %0d expected 1", i, dc); end
      checks++; if (bc != 0) begin errors++; $display("FAIL fast_busy[%0d]: got %0d expected 0", i, bc); end
      checks++; if (dn != 1 || wb != 0) begin errors++; $display("FAIL fast_done_pulse[%0d]: got done=%0d wb_mismatch=%0d expected 1/0", i, dn, wb); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, exp, res; logic [2:0] f3; logic [4:0] rd, rdo; int dc, bc, dn, wb, lat;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7)); a = pick_operand(); b = pick_operand(); rd = 5'($urandom);
      exp = ref_model(f3, a, b);
      lat = ref_latency(f3, a, b);
      run_op(f3, a, b, rd, res, rdo, dc, bc, dn, wb);
      checks++; if (res !== exp || rdo !== rd) begin errors++; $display("FAIL random_result[%0d] f3=%0d a=%h b=%h: got %h rd=%0d expected %h rd=%0d", i, f3, a, b, res, rdo, exp, rd); end
      checks++; if (dc != lat || bc != lat - 1) begin errors++; $display("FAIL random_timing[%0d]: got done@%0d busy=%0d expected done@%0d busy=%0d", i, dc, bc, lat, lat - 1); end
      checks++; if (dn != 1 || wb != 0) begin errors++; $display("FAIL random_done_pulse[%0d]: got done=%0d wb_mismatch=%0d expected 1/0", i, dn, wb); end
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] res; logic [4:0] rdo; int dc = 0, dn = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd4; bus.op_a = 32'd1000; bus.op_b = 32'd7; bus.rd_in = 5'd9;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin dn++; if (dc == 0) begin dc = n; res = bus.result; rdo = bus.rd_out; end end
      if (n == 10) begin bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd5; bus.rd_in = 5'd22; end
      else if (n == 11) bus.start = 1'b0;
    end
    checks++; if (dn != 1) begin errors++; $display("FAIL busy_ignore_done_count: got %0d expected 1", dn); end
    checks++; if (dc != 33) begin errors++; $display("FAIL busy_ignore_latency: got %0d expected 33", dc); end
    checks++; if (res !== 32'd142 || rdo !== 5'd9) begin errors++; $display("FAIL busy_ignore_result: got %h rd=%0d expected 0000008e rd=9", res, rdo); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2; logic [4:0] q1, q2; logic b_after = 1'bx, b_next = 1'bx; int d1 = 0, d2 = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.op_a = 32'd100; bus.op_b = 32'd7; bus.rd_in = 5'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (d1 == 0) begin d1 = n; r1 = bus.result; q1 = bus.rd_out; end
        else if (d2 == 0) begin d2 = n; r2 = bus.result; q2 = bus.rd_out; end
      end
      if (d1 != 0 && n == d1 + 1) b_after = bus.busy;
      if (d1 != 0 && n == d1 + 2) b_next = bus.busy;
      if (d1 != 0 && n == d1) begin bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd6; bus.op_b = 32'd7; bus.rd_in = 5'd4; end
      else if (d1 != 0 && n == d1 + 2) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    checks++; if (d1 != 33 || r1 !== 32'd14 || q1 !== 5'd3) begin errors++; $display("FAIL b2b_first: got done@%0d %h rd=%0d expected done@33 0000000e rd=3", d1, r1, q1); end
    checks++; if (b_after !== 1'b0) begin errors++; $display("FAIL b2b_start_in_done_ignored: got busy=%b expected 0", b_after); end
    checks++; if (b_next !== 1'b1) begin errors++; $display("FAIL b2b_restart_accepted: got busy=%b expected 1", b_next); end
    checks++; if (d2 != d1 + 34) begin errors++; $display("FAIL b2b_second_latency: got %0d expected %0d", d2, d1 + 34); end
    checks++; if (r2 !== 32'd42 || q2 !== 5'd4) begin errors++; $display("FAIL b2b_second_result: got %h rd=%0d expected 0000002a rd=4", r2, q2); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res; logic [4:0] rdo; int dc, bc, dn, wb, stray = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd9; bus.rd_in = 5'd11;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) stray++;
      if (n == 12) rst = 1'b0;
    end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: got busy=%b done=%b expected 0/0", bus.busy, bus.done); end
    checks++; if (bus.result !== 32'h0 || bus.rd_out !== 5'd0) begin errors++; $display("FAIL midreset_outputs: got %h rd=%0d expected 0 rd=0", bus.result, bus.rd_out); end
    rst = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses expected 0", stray); end
    run_op(3'd0, 32'd3, 32'd9, 5'd11, res, rdo, dc, bc, dn, wb);
    checks++; if (res !== 32'd27 || rdo !== 5'd11 || dc != 33) begin errors++; $display("FAIL midreset_recover: got %h rd=%0d done@%0d expected 0000001b rd=11 done@33", res, rdo, dc); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_fast_path();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
